// File: rtl/hazard_md_ctrl_pkg.sv
// Shared MIPS decode constants and the per-instruction hazard class record
// used by the hazard controller and its decoder.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_JR     = 6'h08;
    localparam logic [5:0] F_MFHI   = 6'h10;
    localparam logic [5:0] F_MTHI   = 6'h11;
    localparam logic [5:0] F_MFLO   = 6'h12;
    localparam logic [5:0] F_MTLO   = 6'h13;
    localparam logic [5:0] F_MULT   = 6'h18;
    localparam logic [5:0] F_MULTU  = 6'h19;
    localparam logic [5:0] F_DIV    = 6'h1A;
    localparam logic [5:0] F_DIVU   = 6'h1B;
    localparam logic [5:0] F_ADDU   = 6'h21;
    localparam logic [5:0] F_SUBU   = 6'h23;

    localparam int T_W = 2;
    typedef logic [T_W-1:0] t_t;

    // An absent source gets the largest Tuse so it can never win a compare.
    localparam t_t T_NONE = t_t'(3);

    localparam logic [4:0] REG_RA = 5'd31;

    typedef struct packed {
        logic [4:0] a1;
        logic [4:0] a2;
        logic [4:0] a3;
        t_t         tuse_rs;
        t_t         tuse_rt;
        t_t         tnew_e;
        logic       is_md;
        logic       is_md_start;
        logic       is_div;
    } iclass_t;

endpackage

// File: rtl/hazard_md_ctrl_instr_class.sv
// Combinational decode of one instruction into its register operands,
// Tuse/Tnew timing and multiply/divide family flags.
module instr_class
    import mips_defs::*;
(
    input  logic [31:0] ir,
    output iclass_t     cls
);

    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_shamt;

    assign op = ir[31:26];
    assign fn = ir[5:0];
    assign rs = ir[25:21];
    assign rt = ir[20:16];
    assign rd = ir[15:11];
    assign unused_shamt = ^ir[10:6];

    always_comb begin
        cls = '{a1: 5'd0, a2: 5'd0, a3: 5'd0, tuse_rs: T_NONE, tuse_rt: T_NONE,
                tnew_e: t_t'(0), is_md: 1'b0, is_md_start: 1'b0, is_div: 1'b0};
        if (op == OP_RTYPE) begin
            case (fn)
                F_ADDU, F_SUBU: begin
                    cls.a1 = rs;  cls.tuse_rs = t_t'(1);
                    cls.a2 = rt;  cls.tuse_rt = t_t'(1);
                    cls.a3 = rd;  cls.tnew_e  = t_t'(1);
                end
                F_JR: begin
                    cls.a1 = rs;  cls.tuse_rs = t_t'(0);
                end
                F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                    cls.a1 = rs;  cls.tuse_rs = t_t'(1);
                    cls.a2 = rt;  cls.tuse_rt = t_t'(1);
                    cls.is_md       = 1'b1;
                    cls.is_md_start = 1'b1;
                    cls.is_div      = (fn == F_DIV) || (fn == F_DIVU);
                end
                F_MFHI, F_MFLO: begin
                    cls.a3 = rd;  cls.tnew_e = t_t'(1);
                    cls.is_md = 1'b1;
                end
                F_MTHI, F_MTLO: begin
                    cls.a1 = rs;  cls.tuse_rs = t_t'(1);
                    cls.is_md = 1'b1;
                end
                default: ;
            endcase
        end else begin
            case (op)
                OP_ORI, OP_LW: begin
                    cls.a1 = rs;  cls.tuse_rs = t_t'(1);
                    cls.a3 = rt;
                    cls.tnew_e = (op == OP_LW) ? t_t'(2) : t_t'(1);
                end
                OP_SW: begin
                    cls.a1 = rs;  cls.tuse_rs = t_t'(1);
                    cls.a2 = rt;  cls.tuse_rt = t_t'(2);
                end
                OP_BEQ: begin
                    cls.a1 = rs;  cls.tuse_rs = t_t'(0);
                    cls.a2 = rt;  cls.tuse_rt = t_t'(0);
                end
                OP_LUI: begin
                    cls.a3 = rt;  cls.tnew_e = t_t'(1);
                end
                OP_JAL: begin
                    cls.a3 = REG_RA;  cls.tnew_e = t_t'(0);
                end
                OP_J: ;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hazard_md_ctrl.sv
// D-stage stall decision from Tuse/Tnew rules, multiply/divide busy
// sequencing and a saturating count of stalled cycles.
module hazard_md_ctrl
    import mips_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      ir_d,
    input  logic [31:0]      ir_e,
    input  logic [31:0]      ir_m,
    output logic             stall,
    output logic             ir_e_clr,
    output logic             md_start,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MD_W = $clog2(DIV_CYCLES + 1);
    localparam int S_D  = 0;
    localparam int S_E  = 1;
    localparam int S_M  = 2;

    logic [2:0][31:0] ir_stage;
    iclass_t [2:0]    cls;
    logic             unused_cls;

    assign ir_stage[S_D] = ir_d;
    assign ir_stage[S_E] = ir_e;
    assign ir_stage[S_M] = ir_m;
    assign unused_cls    = ^cls;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dec
        instr_class u_cls (
            .ir  (ir_stage[gi]),
            .cls (cls[gi])
        );
    end

    function automatic logic src_hit(input logic [4:0] a, input logic [4:0] a3,
                                     input t_t tuse, input t_t tnew);
        return (a == a3) && (a3 != 5'd0) && (tuse < tnew);
    endfunction

    // One pipeline stage later the producer is one cycle closer to its result.
    t_t   tnew_m;
    logic data_stall;
    logic md_stall;

    assign tnew_m = (cls[S_M].tnew_e != t_t'(0)) ? t_t'(cls[S_M].tnew_e - t_t'(1)) : t_t'(0);

    assign data_stall = src_hit(cls[S_D].a1, cls[S_E].a3, cls[S_D].tuse_rs, cls[S_E].tnew_e)
                      | src_hit(cls[S_D].a2, cls[S_E].a3, cls[S_D].tuse_rt, cls[S_E].tnew_e)
                      | src_hit(cls[S_D].a1, cls[S_M].a3, cls[S_D].tuse_rs, tnew_m)
                      | src_hit(cls[S_D].a2, cls[S_M].a3, cls[S_D].tuse_rt, tnew_m);

    logic [MD_W-1:0]  md_cnt_reg;
    logic [MD_W-1:0]  md_cnt_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_next;

    assign md_start = cls[S_E].is_md_start;
    assign md_busy  = md_start | (md_cnt_reg != '0);
    assign md_stall = cls[S_D].is_md & md_busy;
    assign stall    = data_stall | md_stall;
    assign ir_e_clr = stall;
    assign stall_cnt = stall_cnt_reg;

    always_comb begin
        md_cnt_next = md_cnt_reg;
        if (md_start && (md_cnt_reg == '0)) begin
            md_cnt_next = cls[S_E].is_div ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
        end else if (md_cnt_reg != '0) begin
            md_cnt_next = md_cnt_reg - MD_W'(1);
        end
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (stall && !(&stall_cnt_reg)) begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_reg    <= '0;
            stall_cnt_reg <= '0;
        end else begin
            md_cnt_reg    <= md_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    // A new MD op can only reach E once the previous one has drained.
    a_no_md_restart: assert property (@(posedge clk) disable iff (reset)
                                      !(md_start && (md_cnt_reg != '0)));

endmodule

// File: tb/tb_hazard_md_ctrl.sv
// Self-checking bench: decode vectors, multi-cycle corner sequences and a
// randomized pipeline checked against a mnemonic-level reference model.
module tb_hazard_md_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset  = 1'b1;
    logic        reset4 = 1'b1;
    logic [31:0] ir_d = '0, ir_e = '0, ir_m = '0;
    logic        stall, ir_e_clr, md_start, md_busy;
    logic [31:0] stall_cnt;
    logic [31:0] ir_d4 = '0, ir_e4 = '0, ir_m4 = '0;
    logic        stall4, unused_clr4, unused_start4, unused_busy4;
    logic [3:0]  stall_cnt4;

    int total = 0;
    int bad   = 0;

    hazard_md_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .ir_d(ir_d), .ir_e(ir_e), .ir_m(ir_m),
        .stall(stall), .ir_e_clr(ir_e_clr), .md_start(md_start),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    hazard_md_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset4), .ir_d(ir_d4), .ir_e(ir_e4), .ir_m(ir_m4),
        .stall(stall4), .ir_e_clr(unused_clr4), .md_start(unused_start4),
        .md_busy(unused_busy4), .stall_cnt(stall_cnt4)
    );

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'h00, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, rs[4:0], rt[4:0], imm};
    endfunction
    function automatic logic [31:0] i_addu(input int d, input int s, input int t); return enc_r(s, t, d, 6'h21); endfunction
    function automatic logic [31:0] i_subu(input int d, input int s, input int t); return enc_r(s, t, d, 6'h23); endfunction
    function automatic logic [31:0] i_jr(input int s);    return enc_r(s, 0, 0, 6'h08); endfunction
    function automatic logic [31:0] i_mult(input int s, input int t);  return enc_r(s, t, 0, 6'h18); endfunction
    function automatic logic [31:0] i_multu(input int s, input int t); return enc_r(s, t, 0, 6'h19); endfunction
    function automatic logic [31:0] i_div(input int s, input int t);   return enc_r(s, t, 0, 6'h1A); endfunction
    function automatic logic [31:0] i_divu(input int s, input int t);  return enc_r(s, t, 0, 6'h1B); endfunction
    function automatic logic [31:0] i_mfhi(input int d); return enc_r(0, 0, d, 6'h10); endfunction
    function automatic logic [31:0] i_mflo(input int d); return enc_r(0, 0, d, 6'h12); endfunction
    function automatic logic [31:0] i_mthi(input int s); return enc_r(s, 0, 0, 6'h11); endfunction
    function automatic logic [31:0] i_mtlo(input int s); return enc_r(s, 0, 0, 6'h13); endfunction
    function automatic logic [31:0] i_ori(input int t, input int s) ; return enc_i(6'h0D, s, t, 16'h00F0); endfunction
    function automatic logic [31:0] i_lw(input int t, input int s)  ; return enc_i(6'h23, s, t, 16'h0004); endfunction
    function automatic logic [31:0] i_sw(input int t, input int s)  ; return enc_i(6'h2B, s, t, 16'h0008); endfunction
    function automatic logic [31:0] i_beq(input int s, input int t) ; return enc_i(6'h04, s, t, 16'h0003); endfunction
    function automatic logic [31:0] i_lui(input int t)              ; return enc_i(6'h0F, 0, t, 16'h1234); endfunction
    function automatic logic [31:0] i_j();   return {6'h02, 26'h0000100}; endfunction
    function automatic logic [31:0] i_jal(); return {6'h03, 26'h0000200}; endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int s0, s1, u0, u1, dst, tnew;
        bit md, mds, dv;
    } info_t;

    function automatic info_t decode(input logic [31:0] ir);
        info_t r;
        string mn;
        logic [5:0] op, fn;
        int rs, rt, rd;
        op = ir[31:26]; fn = ir[5:0];
        rs = int'(ir[25:21]); rt = int'(ir[20:16]); rd = int'(ir[15:11]);
        r.s0 = -1; r.s1 = -1; r.u0 = 9; r.u1 = 9; r.dst = 0; r.tnew = 0;
        r.md = 0; r.mds = 0; r.dv = 0;
        mn = "nop";
        if (op == 6'h00) begin
            case (fn)
                6'h21: mn = "addu";  6'h23: mn = "subu";  6'h08: mn = "jr";
                6'h18: mn = "mult";  6'h19: mn = "multu"; 6'h1A: mn = "div";
                6'h1B: mn = "divu";  6'h10: mn = "mfhi";  6'h12: mn = "mflo";
                6'h11: mn = "mthi";  6'h13: mn = "mtlo";
                default: mn = "nop";
            endcase
        end else begin
            case (op)
                6'h0D: mn = "ori"; 6'h23: mn = "lw";  6'h2B: mn = "sw";
                6'h04: mn = "beq"; 6'h0F: mn = "lui"; 6'h02: mn = "j";
                6'h03: mn = "jal";
                default: mn = "nop";
            endcase
        end
        case (mn)
            "addu", "subu": begin r.s0 = rs; r.u0 = 1; r.s1 = rt; r.u1 = 1; r.dst = rd; r.tnew = 1; end
            "jr":           begin r.s0 = rs; r.u0 = 0; end
            "mult", "multu", "div", "divu": begin
                r.s0 = rs; r.u0 = 1; r.s1 = rt; r.u1 = 1; r.md = 1; r.mds = 1;
                r.dv = (mn == "div") || (mn == "divu");
            end
            "mfhi", "mflo": begin r.dst = rd; r.tnew = 1; r.md = 1; end
            "mthi", "mtlo": begin r.s0 = rs; r.u0 = 1; r.md = 1; end
            "ori":          begin r.s0 = rs; r.u0 = 1; r.dst = rt; r.tnew = 1; end
            "lw":           begin r.s0 = rs; r.u0 = 1; r.dst = rt; r.tnew = 2; end
            "sw":           begin r.s0 = rs; r.u0 = 1; r.s1 = rt; r.u1 = 2; end
            "beq":          begin r.s0 = rs; r.u0 = 0; r.s1 = rt; r.u1 = 0; end
            "lui":          begin r.dst = rt; r.tnew = 1; end
            "jal":          begin r.dst = 31; r.tnew = 0; end
            default: ;
        endcase
        return r;
    endfunction

    function automatic bit hazard(input int src, input int tuse, input int dst, input int tnew);
        return (src > 0) && (src == dst) && (tuse < tnew);
    endfunction

    function automatic bit model_stall(input logic [31:0] d, input logic [31:0] e,
                                       input logic [31:0] m, input bit busy);
        info_t a, x, y;
        int tm;
        a = decode(d); x = decode(e); y = decode(m);
        tm = (y.tnew > 0) ? y.tnew - 1 : 0;
        return hazard(a.s0, a.u0, x.dst, x.tnew) || hazard(a.s1, a.u1, x.dst, x.tnew) ||
               hazard(a.s0, a.u0, y.dst, tm)     || hazard(a.s1, a.u1, y.dst, tm)     ||
               (a.md && busy);
    endfunction

    function automatic logic [31:0] rand_instr();
        int s, t, d;
        s = $urandom_range(0, 3); t = $urandom_range(0, 3); d = $urandom_range(0, 3);
        case ($urandom_range(0, 18))
            0:  return i_addu(d, s, t);   1:  return i_subu(d, s, t);
            2:  return i_jr(s);           3:  return i_mult(s, t);
            4:  return i_multu(s, t);     5:  return i_div(s, t);
            6:  return i_divu(s, t);      7:  return i_mfhi(d);
            8:  return i_mflo(d);         9:  return i_mthi(s);
            10: return i_mtlo(s);         11: return i_ori(t, s);
            12: return i_lw(t, s);        13: return i_sw(t, s);
            14: return i_beq(s, t);       15: return i_lui(t);
            16: return i_j();             17: return i_jal();
            default: return $urandom();
        endcase
    endfunction

    // ---------------- drive / check helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m);
        @(negedge clk);
        ir_d = d; ir_e = e; ir_m = m;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; ir_d = '0; ir_e = '0; ir_m = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_out(input string nm, input bit st, input bit ms, input bit busy);
        chk({nm, ".stall"},    32'(stall),    32'(st));
        chk({nm, ".ir_e_clr"}, 32'(ir_e_clr), 32'(st));
        chk({nm, ".md_start"}, 32'(md_start), 32'(ms));
        chk({nm, ".md_busy"},  32'(md_busy),  32'(busy));
        $display("txn %-14s d=%08h e=%08h m=%08h stall=%0b md_start=%0b md_busy=%0b cnt=%0d",
                 nm, ir_d, ir_e, ir_m, stall, md_start, md_busy, stall_cnt);
    endtask

    typedef struct {
        string       nm;
        logic [31:0] d, e, m;
        bit          st, ms;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input string nm, input logic [31:0] d, input logic [31:0] e,
                           input logic [31:0] m, input bit st, input bit ms);
        vec_t v;
        v.nm = nm; v.d = d; v.e = e; v.m = m; v.st = st; v.ms = ms;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        info_t ie;
        logic [31:0] pd, pe, pm;
        int busy_until, scnt;
        bit exp_st, exp_ms, exp_busy;

        // dut4 sees a permanent lw->addu hazard for the saturation check
        ir_e4 = i_lw(1, 0); ir_d4 = i_addu(2, 1, 3); ir_m4 = '0;

        // ---- reset state ----
        do_reset();
        cyc('0, '0, '0);
        chk_out("reset", 0, 0, 0);
        chk("reset.stall_cnt", stall_cnt, 0);

        // ---- single-cycle decode vectors ----
        add_vec("nop",          '0,              '0,              '0,           0, 0);
        add_vec("lwE_adduD",    i_addu(2, 1, 3), i_lw(1, 0),      '0,           1, 0);
        add_vec("lwM_adduD",    i_addu(2, 1, 3), '0,              i_lw(1, 0),   0, 0);
        add_vec("lwM_beqD",     i_beq(1, 0),     '0,              i_lw(1, 0),   1, 0);
        add_vec("r0_exempt",    i_beq(0, 0),     i_addu(0, 1, 2), '0,           0, 0);
        add_vec("adduE_beqD",   i_beq(4, 5),     i_addu(4, 1, 2), '0,           1, 0);
        add_vec("adduE_swrt",   i_sw(4, 5),      i_addu(4, 1, 2), '0,           0, 0);
        add_vec("lwE_swrt",     i_sw(4, 5),      i_lw(4, 6),      '0,           0, 0);
        add_vec("lwE_swbase",   i_sw(7, 4),      i_lw(4, 6),      '0,           1, 0);
        add_vec("jalE_jr31",    i_jr(31),        i_jal(),         '0,           0, 0);
        add_vec("luiE_jr",      i_jr(7),         i_lui(7),        '0,           1, 0);
        add_vec("multE",        i_addu(8, 9, 10), i_mult(1, 2),   '0,           0, 1);
        add_vec("divE_mfloD",   i_mflo(4),       i_divu(1, 2),    '0,           1, 1);
        add_vec("mfloM_adduD",  i_addu(5, 3, 3), '0,              i_mflo(3),    0, 0);
        add_vec("badop_E",      i_addu(2, 1, 1), {6'h3F, 5'd0, 5'd1, 16'h0}, '0, 0, 0);
        add_vec("oriE_mtloD",   i_mtlo(9),       i_ori(9, 0),     '0,           0, 0);
        add_vec("lwE_mtloD",    i_mtlo(9),       i_lw(9, 0),      '0,           1, 0);
        add_vec("funct0_E",     i_beq(1, 0),     enc_r(0, 0, 1, 6'h00), '0,     0, 0);
        add_vec("mfloE_beqD",   i_beq(6, 0),     i_mflo(6),       '0,           1, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            do_reset();
            cyc(vecs[i].d, vecs[i].e, vecs[i].m);
            chk_out(vecs[i].nm, vecs[i].st, vecs[i].ms, vecs[i].ms);
        end

        // ---- lw in E then M, addu consumer ----
        do_reset();
        cyc(i_addu(2, 1, 3), i_lw(1, 0), '0);
        chk_out("lw_addu.c0", 1, 0, 0);
        cyc(i_addu(2, 1, 3), '0, i_lw(1, 0));
        chk_out("lw_addu.c1", 0, 0, 0);
        chk("lw_addu.stall_cnt", stall_cnt, 1);

        // ---- lw in E then M, beq consumer: two stalls ----
        do_reset();
        cyc(i_beq(1, 0), i_lw(1, 0), '0);
        chk_out("lw_beq.c0", 1, 0, 0);
        cyc(i_beq(1, 0), '0, i_lw(1, 0));
        chk_out("lw_beq.c1", 1, 0, 0);
        cyc(i_beq(1, 0), '0, '0);
        chk_out("lw_beq.c2", 0, 0, 0);
        chk("lw_beq.stall_cnt", stall_cnt, 2);

        // ---- mult in E, mflo waits 6 cycles ----
        do_reset();
        cyc(i_mflo(4), i_mult(1, 2), '0);
        chk_out("mult.t0", 1, 1, 1);
        for (int k = 1; k <= 6; k++) begin
            cyc(i_mflo(4), '0, (k == 1) ? i_mult(1, 2) : 32'h0);
            chk_out($sformatf("mult.t%0d", k), k <= MULT_N, 0, k <= MULT_N);
        end
        chk("mult.stall_cnt", stall_cnt, 6);

        // ---- div in E, independent addu flows, late mfhi waits ----
        do_reset();
        cyc(i_addu(5, 1, 2), i_div(1, 2), '0);
        chk_out("div.t0", 0, 1, 1);
        cyc(i_addu(6, 1, 2), i_addu(5, 1, 2), i_div(1, 2));
        chk_out("div.t1", 0, 0, 1);
        for (int k = 2; k <= 3; k++) begin
            cyc('0, '0, '0);
            chk_out($sformatf("div.t%0d", k), 0, 0, 1);
        end
        for (int k = 4; k <= 11; k++) begin
            cyc(i_mfhi(7), '0, '0);
            chk_out($sformatf("div.t%0d", k), k <= DIV_N, 0, k <= DIV_N);
        end
        chk("div.stall_cnt", stall_cnt, 7);

        // ---- reset while the busy countdown is at 3 ----
        do_reset();
        cyc(i_mflo(4), i_mult(1, 2), '0);
        cyc(i_mflo(4), '0, i_mult(1, 2));
        cyc(i_mflo(4), '0, '0);
        @(negedge clk);
        reset = 1'b1; ir_d = i_mflo(4); ir_e = '0; ir_m = '0;
        #1;
        chk("rstmid.busy_before", 32'(md_busy), 1);
        chk("rstmid.cnt_before", stall_cnt, 3);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(i_mflo(4), '0, '0);
        chk_out("rstmid.after", 0, 0, 0);
        chk("rstmid.stall_cnt", stall_cnt, 0);

        // ---- saturation with a 4-bit counter ----
        @(negedge clk);
        reset4 = 1'b1;
        @(posedge clk);
        #1;
        reset4 = 1'b0;
        chk("sat.after_reset", 32'(stall_cnt4), 0);
        chk("sat.stall", 32'(stall4), 1);
        repeat (10) @(posedge clk);
        #1;
        chk("sat.ten", 32'(stall_cnt4), 10);
        repeat (10) @(posedge clk);
        #1;
        chk("sat.held", 32'(stall_cnt4), 15);
        $display("txn sat            stall_cnt4=%0d after 20 stalled cycles", stall_cnt4);

        // ---- randomized pipeline against the reference model ----
        do_reset();
        pd = '0; pe = '0; pm = '0;
        busy_until = -100;
        scnt = 0;
        for (int c = 0; c < 400; c++) begin
            cyc(pd, pe, pm);
            ie       = decode(pe);
            exp_ms   = ie.mds;
            exp_busy = exp_ms || (c <= busy_until);
            exp_st   = model_stall(pd, pe, pm, exp_busy);
            chk_out($sformatf("rnd%0d", c), exp_st, exp_ms, exp_busy);
            chk($sformatf("rnd%0d.stall_cnt", c), stall_cnt, 32'(scnt));
            if (exp_ms) busy_until = c + (ie.dv ? DIV_N : MULT_N);
            if (exp_st) scnt++;
            pm = pe;
            if (exp_st) begin
                pe = '0;
            end else begin
                pe = pd;
                pd = rand_instr();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_md_ctrl.md
Name: hazard_md_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Decodes the instructions held in the D, E and M pipeline registers and uses Tuse/Tnew rules to decide D-stage stalls.
- Sequences the multiply/divide unit with a busy countdown.
- Drives the PC/D-register freeze and the clear input of the ID/EX register, and exports a saturating stall-cycle counter.

Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu enters E
- DIV_CYCLES, 10, busy cycles after div/divu enters E
- CNT_W, 32, width of stall-cycle counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ir_d  in  32  instruction in the D stage
- ir_e  in  32  instruction in the E stage (ID/EX register output)
- ir_m  in  32  instruction in the M stage
- stall  out  1  freeze PC and IF/ID register (enable = ~stall)
- ir_e_clr  out  1  insert bubble into the ID/EX register at the next edge
- md_start  out  1  E-stage mult/multu/div/divu present; MDU latches operands
- md_busy  out  1  MDU result not yet available
- stall_cnt  out  CNT_W  total stall cycles since reset, saturating

Behaviour:
- Supported set: addu(21) subu(23) jr(08) mult(18) multu(19) div(1A) divu(1B) mfhi(10) mflo(12) mthi(11) mtlo(13) (R-type funct, hex); ori(0D) lw(23) sw(2B) beq(04) lui(0F) j(02) jal(03) (opcodes). All other encodings, including 0, are nops: no sources, no destination.
- Destination (A3):
  - rd for addu/subu/mfhi/mflo.
  - rt for ori/lw/lui.
  - 31 for jal.
  - None otherwise.
- Tuse:
  - beq rs/rt = 0; jr rs = 0.
  - addu/subu rs,rt = 1; ori/lw/sw rs = 1.
  - mult/div family rs,rt = 1; mthi/mtlo rs = 1.
  - sw rt = 2.
- Tnew at E:
  - lw = 2.
  - addu/subu/ori/lui/mfhi/mflo = 1.
  - jal = 0.
- Tnew at M: lw = 1; all others 0.
- Data stall: for stage X in {E, M}, a source of ir_d matches A3_X, A3_X != 0, and Tuse < Tnew_X.
- MD stall: ir_d is in the mult/div/mfhi/mflo/mthi/mtlo family and md_busy = 1.
- stall = data stall | MD stall, combinational. ir_e_clr = stall.
- md_start = ir_e is mult/multu/div/divu, combinational.
- Busy counter md_cnt, width clog2(DIV_CYCLES+1):
  - reset -> 0.
  - md_start and md_cnt == 0 -> load MULT_CYCLES or DIV_CYCLES.
  - else md_cnt > 0 -> decrement.
- md_busy = md_start | (md_cnt != 0). A mult in E with MULT_CYCLES = 5 gives md_busy for 6 consecutive cycles (the E cycle + 5).
- md_start with md_cnt != 0 cannot occur because D is stalled. If it does anyway: no reload, and a simulation assertion fires.
- stall_cnt: reset -> 0; increments on every clk edge where stall = 1; saturates at all-ones.
- Reset mid-operation clears md_cnt and stall_cnt in the same edge. stall is then driven only by the current ir_* values; upstream registers clear to nops, so stall = 0 the cycle after reset.
- Reset outputs:
  - stall = 0, ir_e_clr = 0 (given nop inputs).
  - md_start = 0, md_busy = 0, stall_cnt = 0.
- Simultaneous data and MD stall: a single stall; stall_cnt +1.

Decomposition:
- Shared package mips_defs:
  - opcode/funct constants.
  - Tuse/Tnew width (2 bits).
  - Register index 31 constant.
- Sub-module instr_class: purely combinational decode of one 32-bit instruction to {a1, a2, a3, tuse_rs, tuse_rt, tnew_e, is_md, is_md_start, is_div}.
- instr_class is instantiated three times (D, E, M). The stall comparator and the counters live in the top.

Test Plan:
- lw $1 in E, addu $2,$1,$3 in D -> stall = 1, ir_e_clr = 1 for 1 cycle. Next cycle, with lw in M: stall = 0; stall_cnt = 1.
- lw $1 in E, beq $1,$0 in D -> stall 2 cycles (lw in E, then in M); stall_cnt = 2.
- addu $0,... in E, beq $0 in D -> stall = 0 (register 0 exempt).
- mult in E at cycle t, mflo in D -> md_start = 1 at t; stall for cycles t..t+5; mflo proceeds at t+6; md_cnt reads 5,4,3,2,1,0.
- div in E, then addu in D during busy -> no stall. mfhi arriving after 4 cycles -> stalls until md_cnt = 0 (DIV_CYCLES = 10).
- Reset asserted while md_cnt = 3 -> next cycle md_cnt = 0, md_busy = 0, stall_cnt = 0. With CNT_W = 4 and 20 forced stall cycles -> stall_cnt holds at 15.
